pc_gen: RTL and testbench

Parametrised program-counter generator for the single-issue RISC-V core, successor to the fixed 32-bit PC unit. Holds the fetch PC, resolves branch/jump outcomes from ALU flags, and adds a configurable reset vector, a trap redirect path, misaligned-target detection and a return-address stack (RAS) that feeds return predictions to fetch. Sits between decode/execute (branch info, ALU flags) and instruction fetch (PC out).

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_gen_if.sv | 40 ++++
 rtl/pc_gen_ras_stack.sv | 57 +++++
 rtl/pc_gen.sv | 110 +++++++++++
 tb/tb_pc_gen.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program-counter generator: jump/branch classes and the
// fixed instruction size.
package pc_pkg;

    typedef enum logic [2:0] {
        JMP_NONE = 3'd0,
        JMP_JAL  = 3'd1,
        JMP_JALR = 3'd2,
        JMP_BEQ  = 3'd3,
        JMP_BNE  = 3'd4,
        JMP_BLT  = 3'd5,
        JMP_BGE  = 3'd6,
        JMP_RSVD = 3'd7
    } jmp_t;

    localparam int INSN_BYTES = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Bundle between decode/execute, fetch and the PC generator. The master side
// supplies branch information; the slave side (pc_gen) returns PC and RAS state.
interface pc_gen_if
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic            stay;
    jmp_t            branch_type;
    logic            alu_zero;
    logic            alu_lt;
    logic [XLEN-1:0] pc_offset;
    logic [XLEN-1:0] target_pc;
    logic            rd_link;
    logic            rs1_link;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] return_pc;
    logic [XLEN-1:0] ras_top;
    logic            ras_valid;
    logic            misalign;
    logic [XLEN-1:0] misalign_addr;
    logic            ras_miss;

    modport master (
        output stay, branch_type, alu_zero, alu_lt, pc_offset, target_pc,
               rd_link, rs1_link, trap_req, trap_vec,
        input  pc, return_pc, ras_top, ras_valid, misalign, misalign_addr, ras_miss
    );

    modport slave (
        input  stay, branch_type, alu_zero, alu_lt, pc_offset, target_pc,
               rd_link, rs1_link, trap_req, trap_vec,
        output pc, return_pc, ras_top, ras_valid, misalign, misalign_addr, ras_miss
    );

endinterface

// File: rtl/pc_gen_ras_stack.sv
// Return-address stack with a circular top pointer: pushing when full silently
// overwrites the oldest entry, popping when empty is a no-op.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            replace,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] top,
    output logic            valid
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  entries [RAS_DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_inc;
    logic [PTR_W-1:0] sp_dec;
    logic [CNT_W-1:0] count;

    assign sp_inc = sp + PTR_W'(1);
    assign sp_dec = sp - PTR_W'(1);
    assign valid  = (count != '0);
    assign top    = valid ? entries[sp] : '0;

    // Control state: pointer and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
        end else if (push) begin
            sp    <= sp_inc;
            count <= (count == FULL) ? count : count + CNT_W'(1);
        end else if (pop && valid) begin
            sp    <= sp_dec;
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage carries no reset; stale slots are masked by the count
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push) begin
                entries[sp_inc] <= data;
            end else if (replace) begin
                entries[sp] <= data;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register and next-PC selection: branch resolution, trap redirect,
// misaligned-target detection and return-address prediction.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input logic   clk,
    input logic   rst,
    pc_gen_if.slave bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            is_jal;
    logic            is_jalr;
    logic            misaligned;
    logic            ras_en;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_replace;
    logic            miss_next;
    logic [XLEN-1:0] ras_top;
    logic            ras_valid;
    logic            misalign_q;
    logic [XLEN-1:0] misalign_addr_q;
    logic            ras_miss_q;
    logic            unused_target_lsb;

    // JALR clears bit 0 of its target, so that input bit is never observed
    assign unused_target_lsb = bus.target_pc[0];

    assign seq_pc  = pc_q + XLEN'(INSN_BYTES);
    assign is_jal  = (bus.branch_type == JMP_JAL);
    assign is_jalr = (bus.branch_type == JMP_JALR);

    always_comb begin
        taken = 1'b0;
        case (bus.branch_type)
            JMP_JAL, JMP_JALR: taken = 1'b1;
            JMP_BEQ:           taken = bus.alu_zero;
            JMP_BNE:           taken = !bus.alu_zero;
            JMP_BLT:           taken = bus.alu_lt;
            JMP_BGE:           taken = !bus.alu_lt;
            default:           taken = 1'b0;
        endcase
    end

    assign target     = is_jalr ? {bus.target_pc[XLEN-1:1], 1'b0} : pc_q + bus.pc_offset;
    assign misaligned = taken && target[1];

    // RAS only moves on a jump that actually commits this cycle
    assign ras_en      = (is_jal || is_jalr) && !bus.trap_req && !bus.stay && !misaligned;
    assign ras_push    = ras_en && bus.rd_link && !(is_jalr && bus.rs1_link);
    assign ras_pop     = ras_en && is_jalr && bus.rs1_link && !bus.rd_link;
    assign ras_replace = ras_en && is_jalr && bus.rs1_link && bus.rd_link;
    assign miss_next   = (ras_pop || ras_replace) && ras_valid && (target != ras_top);

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (ras_push),
        .pop     (ras_pop),
        .replace (ras_replace),
        .data    (seq_pc),
        .top     (ras_top),
        .valid   (ras_valid)
    );

    // PC register and event outputs; pulses default low every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_VECTOR;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            ras_miss_q      <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            ras_miss_q <= 1'b0;
            if (bus.trap_req) begin
                pc_q <= bus.trap_vec;
            end else if (bus.stay) begin
                pc_q <= pc_q;
            end else if (misaligned) begin
                pc_q            <= bus.trap_vec;
                misalign_q      <= 1'b1;
                misalign_addr_q <= target;
            end else begin
                pc_q       <= taken ? target : seq_pc;
                ras_miss_q <= miss_next;
            end
        end
    end

    assign bus.pc            = pc_q;
    assign bus.return_pc     = seq_pc;
    assign bus.ras_top       = ras_top;
    assign bus.ras_valid     = ras_valid;
    assign bus.misalign      = misalign_q;
    assign bus.misalign_addr = misalign_addr_q;
    assign bus.ras_miss      = ras_miss_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of fetch PC and return-address stack.
module tb_pc_gen;
    import pc_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h100;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: values the DUT should show after the next edge
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_mis;
    logic [31:0] m_mis_addr;
    logic        m_miss;

    pc_gen_if #(.XLEN(XLEN)) bus ();

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r, input logic trap, input logic stl, input int bt,
                       input logic zero, input logic lt, input logic [31:0] off,
                       input logic [31:0] tgt, input logic rd, input logic rs1,
                       input logic [31:0] tvec);
        rst             = r;
        bus.trap_req    = trap;
        bus.stay        = stl;
        bus.branch_type = jmp_t'(bt[2:0]);
        bus.alu_zero    = zero;
        bus.alu_lt      = lt;
        bus.pc_offset   = off;
        bus.target_pc   = tgt;
        bus.rd_link     = rd;
        bus.rs1_link    = rs1;
        bus.trap_vec    = tvec;
    endtask

    task automatic model_next();
        int          bt;
        bit          taken;
        bit          jal;
        bit          jalr;
        logic [31:0] tgt;
        logic [31:0] link;
        bt    = int'(bus.branch_type);
        jal   = (bt == 1);
        jalr  = (bt == 2);
        taken = 1'b0;
        case (bt)
            1, 2: taken = 1'b1;
            3:    taken = bus.alu_zero;
            4:    taken = !bus.alu_zero;
            5:    taken = bus.alu_lt;
            6:    taken = !bus.alu_lt;
            default: taken = 1'b0;
        endcase
        tgt    = jalr ? (bus.target_pc & 32'hFFFF_FFFE) : (m_pc + bus.pc_offset);
        link   = m_pc + 32'd4;
        m_mis  = 1'b0;
        m_miss = 1'b0;
        if (rst) begin
            m_pc       = RV;
            m_ras.delete();
            m_mis_addr = 32'h0;
        end else if (bus.trap_req) begin
            m_pc = bus.trap_vec;
        end else if (bus.stay) begin
            m_pc = m_pc;
        end else if (taken && tgt[1]) begin
            m_pc       = bus.trap_vec;
            m_mis      = 1'b1;
            m_mis_addr = tgt;
        end else begin
            if (jalr && bus.rs1_link) begin
                if (m_ras.size() > 0 && tgt != m_ras[$]) m_miss = 1'b1;
                if (bus.rd_link) begin
                    if (m_ras.size() > 0) m_ras[m_ras.size() - 1] = link;
                end else if (m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end else if ((jal || jalr) && bus.rd_link) begin
                m_ras.push_back(link);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = taken ? tgt : link;
        end
    endtask

    task automatic step(input string tag);
        logic [31:0] exp_top;
        model_next();
        @(posedge clk);
        #1;
        exp_top = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
        check({tag, ".pc"}, bus.pc, m_pc);
        check({tag, ".return_pc"}, bus.return_pc, m_pc + 32'd4);
        check({tag, ".ras_valid"}, {31'b0, bus.ras_valid}, {31'b0, m_ras.size() > 0});
        check({tag, ".ras_top"}, bus.ras_top, exp_top);
        check({tag, ".misalign"}, {31'b0, bus.misalign}, {31'b0, m_mis});
        check({tag, ".misalign_addr"}, bus.misalign_addr, m_mis_addr);
        check({tag, ".ras_miss"}, {31'b0, bus.ras_miss}, {31'b0, m_miss});
    endtask

    initial begin
        logic [31:0] off;
        logic [31:0] tgt;
        logic [31:0] a;

        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        step("reset");
        check("plan.reset_pc", bus.pc, 32'h100);
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
            step("seq");
        end
        check("plan.seq_pc", bus.pc, 32'h10C);

        drv(0, 0, 0, 2, 0, 0, 0, 32'h200, 0, 0, 32'h0);
        step("jalr_200");
        drv(0, 0, 0, 4, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0);
        step("bne_taken");
        check("plan.bne_taken", bus.pc, 32'h1F0);
        drv(0, 0, 0, 2, 0, 0, 0, 32'h200, 0, 0, 32'h0);
        step("jalr_200b");
        drv(0, 0, 0, 4, 1, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0);
        step("bne_not_taken");
        check("plan.bne_not_taken", bus.pc, 32'h204);

        drv(0, 0, 0, 2, 0, 0, 0, 32'h301, 0, 0, 32'h80);
        step("jalr_lsb");
        check("plan.jalr_lsb", bus.pc, 32'h300);
        drv(0, 0, 0, 2, 0, 0, 0, 32'h302, 0, 0, 32'h80);
        step("jalr_misalign");
        check("plan.mis_pc", bus.pc, 32'h80);
        check("plan.mis_pulse", {31'b0, bus.misalign}, 32'h1);
        check("plan.mis_addr", bus.misalign_addr, 32'h302);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        step("mis_clear");
        check("plan.mis_one_cycle", {31'b0, bus.misalign}, 32'h0);

        for (int i = 1; i <= 5; i++) begin
            a = 32'(i * 16);
            drv(0, 0, 0, 2, 0, 0, 0, a, 0, 0, 32'h0);
            step("goto_call_site");
            drv(0, 0, 0, 1, 0, 0, 32'h1000, 0, 1, 0, 32'h0);
            step("jal_call");
        end
        check("plan.ras_top_54", bus.ras_top, 32'h54);

        drv(0, 0, 0, 2, 0, 0, 0, 32'h60, 0, 1, 32'h0);
        step("ret_mispredict");
        check("plan.ras_miss", {31'b0, bus.ras_miss}, 32'h1);
        for (int i = 4; i >= 2; i--) begin
            drv(0, 0, 0, 2, 0, 0, 0, 32'(i * 16 + 4), 0, 1, 32'h0);
            step("ret");
        end
        check("plan.ras_empty", {31'b0, bus.ras_valid}, 32'h0);
        drv(0, 0, 0, 2, 0, 0, 0, 32'h70, 0, 1, 32'h0);
        step("ret_underflow");
        check("plan.underflow_no_miss", {31'b0, bus.ras_miss}, 32'h0);

        drv(0, 0, 0, 1, 0, 0, 32'h40, 0, 1, 0, 32'h0);
        step("jal_push");
        drv(0, 0, 1, 1, 0, 0, 32'h40, 0, 1, 0, 32'h0);
        step("stay_jal");
        drv(0, 0, 1, 1, 0, 0, 32'h40, 0, 1, 1, 32'h0);
        step("stay_jal2");
        drv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h40);
        step("stay_trap");
        check("plan.stay_trap", bus.pc, 32'h40);
        drv(0, 1, 0, 1, 0, 0, 32'h40, 0, 1, 0, 32'h88);
        step("trap_over_jal");
        drv(1, 0, 0, 1, 0, 0, 32'h40, 0, 1, 0, 32'h0);
        step("rst_with_jal");
        check("plan.rst_pc", bus.pc, 32'h100);
        check("plan.rst_ras", {31'b0, bus.ras_valid}, 32'h0);

        for (int n = 0; n < 600; n++) begin
            off = $urandom & 32'h0000_1FFC;
            if ($urandom_range(0, 7) == 0) off = off | 32'h2;
            if ($urandom_range(0, 1) == 1) off = -off;
            tgt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) tgt = tgt | 32'h2;
            if ($urandom_range(0, 2) == 0 && m_ras.size() > 0) tgt = m_ras[$];
            drv(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 6) == 0), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), off, tgt,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom & 32'hFFFF_FFFC);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
